mem_stage: RTL

Memory-access pipeline stage between the execute stage and the write-back stage. Accepts the execute-stage bus, waits for the data-side sram-like response of every load/store, extracts and extends load data, and produces the write-back bus. Also drives the memory-stage forwarding bus and reports exceptions. Absorbs early data responses and discards responses belonging to flushed instructions.

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: pairs data-side responses with loads/stores,
// extracts load data, and drives the write-back and forwarding buses.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 129,
  parameter int MS_TO_WS_BUS_WD = 124,
  parameter int MS_FWD_BUS_WD   = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_req,
  input  logic                       data_sram_addr_ok,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
  output logic                       ms_ex,
  input  logic                       flush
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;

  logic        w_store_op;
  logic [31:0] w_badvaddr;
  logic [10:0] w_c0_bus;
  logic        w_bd;
  logic        w_ex;
  logic [4:0]  w_excode;
  logic        w_lw, w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_res;
  logic [31:0] w_pc;

  assign w_store_op     = r_es_bus[128];
  assign w_badvaddr     = r_es_bus[127:96];
  assign w_c0_bus       = r_es_bus[95:85];
  assign w_bd           = r_es_bus[84];
  assign w_ex           = r_es_bus[83];
  assign w_excode       = r_es_bus[82:78];
  assign w_lw           = r_es_bus[77];
  assign w_lb           = r_es_bus[76];
  assign w_lbu          = r_es_bus[75];
  assign w_lh           = r_es_bus[74];
  assign w_lhu          = r_es_bus[73];
  assign w_lwl          = r_es_bus[72];
  assign w_lwr          = r_es_bus[71];
  assign w_res_from_mem = r_es_bus[70];
  assign w_gr_we        = r_es_bus[69];
  assign w_dest         = r_es_bus[68:64];
  assign w_res          = r_es_bus[63:32];
  assign w_pc           = r_es_bus[31:0];

  // Request/response bookkeeping: outstanding tracks every accepted request,
  // discard counts responses still owed to instructions killed by a flush.
  logic [1:0] r_outstanding, r_discard;
  logic [1:0] w_out_next;
  logic       w_inc, w_dec, w_resp_live;

  assign w_inc       = data_sram_req & data_sram_addr_ok;
  assign w_dec       = data_sram_data_ok;
  assign w_out_next  = r_outstanding + {1'b0, w_inc} - {1'b0, w_dec};
  assign w_resp_live = data_sram_data_ok & (r_discard == 2'd0) & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= 2'd0;
      r_discard     <= 2'd0;
    end else begin
      r_outstanding <= w_out_next;
      if (flush)
        r_discard <= w_out_next;
      else if (w_dec && r_discard != 2'd0)
        r_discard <= r_discard - 2'd1;
    end
  end

  logic [31:0] r_fifo_mem [2];
  logic        r_rd_ptr, r_wr_ptr;
  logic [1:0]  r_fifo_cnt;
  logic        w_fifo_empty, w_data_avail, w_mem_wait, w_ready_go;
  logic        w_retire_mem, w_push, w_pop;
  logic [31:0] w_word;

  assign w_fifo_empty = (r_fifo_cnt == 2'd0);
  assign w_data_avail = ~w_fifo_empty | w_resp_live;
  assign w_word       = w_fifo_empty ? data_sram_rdata : r_fifo_mem[r_rd_ptr];
  assign w_mem_wait   = (w_res_from_mem | w_store_op) & ~w_ex;
  assign w_ready_go   = ~w_mem_wait | w_data_avail;

  assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~flush;

  // A response consumed straight off the bus in its arrival cycle is never queued.
  assign w_retire_mem = ms_to_ws_valid & ws_allowin & w_mem_wait;
  assign w_pop        = w_retire_mem & ~w_fifo_empty;
  assign w_push       = w_resp_live & ~(w_retire_mem & w_fifo_empty);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= data_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ms_valid <= 1'b0;
    else if (flush)
      r_ms_valid <= 1'b0;
    else if (ms_allowin)
      r_ms_valid <= es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) r_es_bus <= es_to_ms_bus;
  end

  logic [1:0]  w_p;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_final;
  logic [3:0]  w_wstrb;

  assign w_p    = w_res[1:0];
  assign w_byte = w_word[{w_p, 3'b000} +: 8];
  assign w_half = w_p[1] ? w_word[31:16] : w_word[15:0];

  // Partial-word loads return byte strobes so write-back can merge with the old register.
  always_comb begin
    w_final = w_res;
    w_wstrb = {4{w_gr_we}};
    if (w_res_from_mem && !w_ex) begin
      w_wstrb = 4'b1111;
      w_final = w_word;
      if (w_lw) begin
        w_final = w_word;
      end else if (w_lb || w_lbu) begin
        w_final = {{24{w_lb & w_byte[7]}}, w_byte};
      end else if (w_lh || w_lhu) begin
        w_final = {{16{w_lh & w_half[15]}}, w_half};
      end else if (w_lwl) begin
        case (w_p)
          2'd0:    begin w_final = {w_word[7:0], 24'd0};  w_wstrb = 4'b1000; end
          2'd1:    begin w_final = {w_word[15:0], 16'd0}; w_wstrb = 4'b1100; end
          2'd2:    begin w_final = {w_word[23:0], 8'd0};  w_wstrb = 4'b1110; end
          default: begin w_final = w_word;                w_wstrb = 4'b1111; end
        endcase
      end else if (w_lwr) begin
        case (w_p)
          2'd0:    begin w_final = w_word;                 w_wstrb = 4'b1111; end
          2'd1:    begin w_final = {8'd0, w_word[31:8]};   w_wstrb = 4'b0111; end
          2'd2:    begin w_final = {16'd0, w_word[31:16]}; w_wstrb = 4'b0011; end
          default: begin w_final = {24'd0, w_word[31:24]}; w_wstrb = 4'b0001; end
        endcase
      end
    end
  end

  assign ms_to_ws_bus = {w_badvaddr, w_c0_bus, w_bd, w_ex, w_excode, w_wstrb,
                         w_gr_we & ~w_ex, w_dest, w_final, w_pc};

  assign ms_fwd_bus = {r_ms_valid & w_c0_bus[8],
                       r_ms_valid & w_res_from_mem & ~w_data_avail,
                       r_ms_valid & w_gr_we & ~flush,
                       w_dest, w_final};

  assign ms_ex = r_ms_valid & w_ex;

endmodule
